// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared types and constants for the RTC timebase and the frame-timestamp
// logic. Field widths and per-field maximum values are defined here. The packed
// time struct is the timestamp format attached to extracted spectrogram frames.
// -----------------------------------------------------------------------------
package rtc_pkg;

    localparam int MS_W   = 10;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;

    localparam logic [MS_W-1:0]   MS_MAX   = 10'd999;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef struct packed {
        logic [DAY_W-1:0]  day;
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MS_W-1:0]   ms;
    } rtc_time_t;

    // A field above its legal maximum is replaced by zero. The day limit
    // depends on the period length, so the caller passes it in.
    function automatic rtc_time_t rtc_sanitize(input rtc_time_t t,
                                               input logic [DAY_W-1:0] day_last);
        rtc_time_t r;
        r = t;
        if (t.ms   > MS_MAX)   r.ms   = '0;
        if (t.sec  > SEC_MAX)  r.sec  = '0;
        if (t.min  > MIN_MAX)  r.min  = '0;
        if (t.hour > HOUR_MAX) r.hour = '0;
        if (t.day  > day_last) r.day  = '0;
        return r;
    endfunction

endpackage

// File: rtl/rtc_timebase_if.sv
// -----------------------------------------------------------------------------
// rtc_timebase_if
// Control/status bundle of the RTC timebase.
//   master : drives run enable, time load, alarm programming and alarm clear;
//            observes the current time, tick, day_wrap and alarm_irq.
//   slave  : the timebase itself (opposite directions).
// -----------------------------------------------------------------------------
interface rtc_timebase_if;
    import rtc_pkg::*;

    // control
    logic              en;
    logic              load;
    logic [MS_W-1:0]   ld_ms;
    logic [SEC_W-1:0]  ld_sec;
    logic [MIN_W-1:0]  ld_min;
    logic [HOUR_W-1:0] ld_hour;
    logic [DAY_W-1:0]  ld_day;
    logic              alarm_wr;
    logic [SEC_W-1:0]  al_sec;
    logic [MIN_W-1:0]  al_min;
    logic [HOUR_W-1:0] al_hour;
    logic              alarm_clr;

    // status
    logic [MS_W-1:0]   millisec;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
    logic [DAY_W-1:0]  day;
    logic              tick;
    logic              day_wrap;
    logic              alarm_irq;

    modport master (
        output en, load, ld_ms, ld_sec, ld_min, ld_hour, ld_day,
               alarm_wr, al_sec, al_min, al_hour, alarm_clr,
        input  millisec, sec, min, hour, day, tick, day_wrap, alarm_irq
    );

    modport slave (
        input  en, load, ld_ms, ld_sec, ld_min, ld_hour, ld_day,
               alarm_wr, al_sec, al_min, al_hour, alarm_clr,
        output millisec, sec, min, hour, day, tick, day_wrap, alarm_irq
    );

endinterface

// File: rtl/rtc_prescaler.sv
// -----------------------------------------------------------------------------
// rtc_prescaler
// Divides the system clock down to the millisecond tick.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   i_en   : 1 = count, 0 = freeze the prescale counter
//   i_clr  : restart the prescale period (time load)
//   o_tick : combinational, high in the enabled cycle that ends a period
// -----------------------------------------------------------------------------
module rtc_prescaler #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    // Keep at least one bit so CLK_DIV=1 still elaborates; the counter
    // then never leaves 0 and every enabled cycle is a tick.
    localparam int              PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_pcnt;
    logic          w_last;

    assign w_last = (r_pcnt == LAST);
    assign o_tick = i_en & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else if (i_clr) begin
            r_pcnt <= '0;
        end else if (i_en) begin
            r_pcnt <= w_last ? '0 : r_pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/rtc_timebase.sv
// -----------------------------------------------------------------------------
// rtc_timebase
// Real-time-clock timebase: ms/sec/min/hour/day counters driven by a clock
// prescaler, with synchronous time load, run/stop and an hh:mm:ss alarm.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rtc_timebase_if.slave
//           in : en, load, ld_ms/sec/min/hour/day, alarm_wr,
//                al_sec/min/hour, alarm_clr
//           out: millisec, sec, min, hour, day, tick, day_wrap, alarm_irq
// Parameters: CLK_DIV (clk cycles per ms), DAYS (days per period, 2..32),
//             ALARM_EN (0 removes the alarm logic, alarm_irq reads 0).
// -----------------------------------------------------------------------------
module rtc_timebase
    import rtc_pkg::*;
#(
    parameter int CLK_DIV  = 1,
    parameter int DAYS     = 31,
    parameter int ALARM_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    rtc_timebase_if.slave bus
);

    localparam logic [DAY_W-1:0] DAY_LAST = DAY_W'(DAYS - 1);

    logic      w_tick_i;
    logic      w_adv;
    logic      w_ms_wrap, w_sec_wrap, w_min_wrap, w_hour_wrap, w_day_wrap;
    rtc_time_t r_time;
    rtc_time_t w_inc;
    rtc_time_t w_ld_time;
    rtc_time_t w_time_next;
    logic      r_tick;
    logic      r_day_wrap;

    rtc_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (bus.en),
        .i_clr  (bus.load),
        .o_tick (w_tick_i)
    );

    // A load in the same cycle swallows the tick.
    assign w_adv = w_tick_i & ~bus.load;

    // Carry chain: each wrap term means "this field and all below roll over".
    assign w_ms_wrap   = (r_time.ms == MS_MAX);
    assign w_sec_wrap  = w_ms_wrap   && (r_time.sec  == SEC_MAX);
    assign w_min_wrap  = w_sec_wrap  && (r_time.min  == MIN_MAX);
    assign w_hour_wrap = w_min_wrap  && (r_time.hour == HOUR_MAX);
    assign w_day_wrap  = w_hour_wrap && (r_time.day  == DAY_LAST);

    always_comb begin
        w_inc = r_time;
        w_inc.ms = w_ms_wrap ? '0 : r_time.ms + 1'b1;
        if (w_ms_wrap)   w_inc.sec  = w_sec_wrap  ? '0 : r_time.sec  + 1'b1;
        if (w_sec_wrap)  w_inc.min  = w_min_wrap  ? '0 : r_time.min  + 1'b1;
        if (w_min_wrap)  w_inc.hour = w_hour_wrap ? '0 : r_time.hour + 1'b1;
        if (w_hour_wrap) w_inc.day  = w_day_wrap  ? '0 : r_time.day  + 1'b1;
    end

    assign w_ld_time = rtc_sanitize('{day:  bus.ld_day,  hour: bus.ld_hour,
                                      min:  bus.ld_min,  sec:  bus.ld_sec,
                                      ms:   bus.ld_ms}, DAY_LAST);

    always_comb begin
        w_time_next = r_time;
        if (bus.load)      w_time_next = w_ld_time;
        else if (w_tick_i) w_time_next = w_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time     <= '0;
            r_tick     <= 1'b0;
            r_day_wrap <= 1'b0;
        end else begin
            r_time     <= w_time_next;
            r_tick     <= w_adv;
            r_day_wrap <= w_adv & w_day_wrap;
        end
    end

    assign bus.millisec = r_time.ms;
    assign bus.sec      = r_time.sec;
    assign bus.min      = r_time.min;
    assign bus.hour     = r_time.hour;
    assign bus.day      = r_time.day;
    assign bus.tick     = r_tick;
    assign bus.day_wrap = r_day_wrap;

    generate
        if (ALARM_EN != 0) begin : g_alarm
            logic [SEC_W-1:0]  r_al_sec;
            logic [MIN_W-1:0]  r_al_min;
            logic [HOUR_W-1:0] r_al_hour;
            logic              r_armed;
            logic              r_irq;
            logic              w_event;
            logic              w_match;

            // Compare against the value about to be registered, so a match
            // is seen both when counting into the alarm time and when the
            // alarm time is loaded directly. alarm_wr in the same cycle
            // only updates the registers at the edge, so the old ones apply.
            assign w_event = bus.load | w_tick_i;
            assign w_match = r_armed && w_event
                          && (w_time_next.ms   == '0)
                          && (w_time_next.sec  == r_al_sec)
                          && (w_time_next.min  == r_al_min)
                          && (w_time_next.hour == r_al_hour);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_al_sec  <= '0;
                    r_al_min  <= '0;
                    r_al_hour <= '0;
                    r_armed   <= 1'b0;
                    r_irq     <= 1'b0;
                end else begin
                    if (bus.alarm_wr) begin
                        r_al_sec  <= bus.al_sec;
                        r_al_min  <= bus.al_min;
                        r_al_hour <= bus.al_hour;
                        r_armed   <= 1'b1;
                    end
                    // set beats clear
                    if (w_match)            r_irq <= 1'b1;
                    else if (bus.alarm_clr) r_irq <= 1'b0;
                end
            end

            assign bus.alarm_irq = r_irq;
        end else begin : g_no_alarm
            assign bus.alarm_irq = 1'b0;
        end
    endgenerate

endmodule

// File: doc/rtc_timebase.md
Name: rtc_timebase

Overview:
Parametrised real-time-clock timebase for the spectrogram extractor. It counts millisecond/second/minute/hour/day from a programmable clock prescaler, supports a synchronous time-load port and a run/stop enable, and raises a sticky alarm on an hour:minute:second match. It timestamps extracted spectrogram frames and replaces the fixed-rate free-running counter.

Parameters:
CLK_DIV, 1, clk cycles per millisecond tick (>=1); 1 = tick every enabled cycle
DAYS, 31, days per period; day counts 0..DAYS-1 (range 2..32)
ALARM_EN, 1, 1 = alarm logic present; 0 = alarm_irq tied 0, alarm inputs ignored

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  1 = count; 0 = hold all counters and prescaler
load  in  1  single-cycle strobe: load time from ld_* fields
ld_ms  in  10  load value, millisecond
ld_sec  in  6  load value, second
ld_min  in  6  load value, minute
ld_hour  in  5  load value, hour
ld_day  in  5  load value, day
alarm_wr  in  1  strobe: capture al_sec/al_min/al_hour, arm alarm
al_sec  in  6  alarm second
al_min  in  6  alarm minute
al_hour  in  5  alarm hour
alarm_clr  in  1  clears alarm_irq
millisec  out  10  current millisecond 0..999
sec  out  6  current second 0..59
min  out  6  current minute 0..59
hour  out  5  current hour 0..23
day  out  5  current day 0..DAYS-1
tick  out  1  one-cycle pulse, same cycle the ms counter advances
day_wrap  out  1  one-cycle pulse when day rolls DAYS-1 -> 0
alarm_irq  out  1  sticky alarm flag

Behaviour:
- Reset (reset=0, async): all time fields 0, prescaler 0, tick/day_wrap/alarm_irq 0, alarm regs 0, alarm disarmed.
- Prescaler: pcnt 0..CLK_DIV-1, advances only when en=1; internal tick_i when en=1 and pcnt==CLK_DIV-1, then pcnt->0. en=0 freezes pcnt.
- tick output is registered: it goes high in the cycle the new millisec value becomes visible.
- On tick_i, cascade carry: ms 999->0 carries to sec; sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0 carries to day; day DAYS-1->0 asserts day_wrap. Each field increments only on its carry; there is no double increment.
- load=1 has priority over tick_i in the same cycle: fields <= ld_*, pcnt <= 0, no tick, no day_wrap. A field above its max (ms>999, sec/min>59, hour>23, day>DAYS-1) loads as 0. load works regardless of en.
- alarm_wr: captures the alarm time and sets armed=1. Alarm time fields are not range-checked; an unreachable value never matches.
- Match: armed and a tick_i results in sec/min/hour == alarm regs with millisec==0. Evaluated on the post-increment value, and also on load of a matching value with ld_ms==0. On match, alarm_irq <= 1 next cycle, sticky. Alarm stays armed, so it fires once per day.
- alarm_clr clears alarm_irq. If alarm_clr and a match occur in the same cycle, the set wins. alarm_wr in the same cycle as a match uses the old alarm registers.
- Reset mid-operation: immediate return to reset values. There is no partial-state retention.

Decomposition:
- Package rtc_pkg: field widths (MS_W=10, SEC_W=6, MIN_W=6, HOUR_W=5, DAY_W=5), constants MS_MAX=999, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, and a packed struct rtc_time_t {day,hour,min,sec,ms} shared with the frame-timestamp logic.
- Sub-module rtc_prescaler (CLK_DIV, clk, reset, en, clr -> tick_i). The cascade and the alarm logic stay in rtc_timebase.

Test Plan:
- Reset/prescaler: CLK_DIV=4, en=1 from reset -> tick every 4th cycle, millisec=1 after 4 cycles, 250 after 1000 cycles; en=0 for 10 cycles -> all outputs frozen.
- Full cascade: load ms=999 sec=59 min=59 hour=23 day=30, DAYS=31, next tick -> all fields 0, day_wrap=1 for exactly one cycle.
- Intermediate carry: load 999/59/12/5/3 -> next tick gives 0/0/13/5/3; load 999/10/... -> sec 11 only.
- Load vs tick collision: assert load on a tick_i cycle with ld=500/30/30/10/7 -> outputs 500/30/30/10/7, tick=0, next tick 3 cycles+1 later (CLK_DIV=4); load sec=61 -> sec=0.
- Alarm: alarm_wr 00:00:05 at 00:00:04.998 -> alarm_irq rises 1 cycle after ms 999->0 at second 5; stays 1; alarm_clr -> 0; clr with simultaneous match -> remains 1.
- Async reset mid-count at 12:34:56.789 -> all outputs 0 immediately with no clk edge; alarm disarmed, no irq at the old alarm time.
